// File: rtl/alu_share_pkg.sv
// Shared FSM states, ALU opcodes and the compensation helper for alu_share_arb.
// Defining ALU_SHARE_COMP_EN adds the COMP state and alu_comp().
package alu_share_pkg;

    localparam logic [2:0] SEL_ADD   = 3'b000;
    localparam logic [2:0] SEL_SUB   = 3'b001;
    localparam logic [2:0] SEL_AND   = 3'b010;
    localparam logic [2:0] SEL_OR    = 3'b011;
    localparam logic [2:0] SEL_XOR   = 3'b100;
    localparam logic [2:0] SEL_SHL   = 3'b101;
    localparam logic [2:0] SEL_SHR   = 3'b110;
    localparam logic [2:0] SEL_PASSB = 3'b111;

`ifdef ALU_SHARE_COMP_EN
    localparam int COMP_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2,
        ST_COMP = 2'd3
    } state_e;

    // Correction term for the approximate adder's two low carry positions.
    function automatic logic [COMP_W-1:0] alu_comp(input logic [COMP_W-1:0] a,
                                                   input logic [COMP_W-1:0] b);
        alu_comp = {{(COMP_W-3){1'b0}}, a[1] & b[1], a[0] & b[0], 1'b0};
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;
`endif

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    always_comb begin
        int          j;
        logic        found;
        logic [IDW-1:0] jIdx;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        jIdx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jIdx = IDW'(j);
            if (!found && req_i[jIdx]) begin
                found       = 1'b1;
                gnt_o[jIdx] = 1'b1;
                idx_o       = jIdx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU among NREQ requesters with round-robin grants.
// Define ALU_SHARE_COMP_EN to add a compensation pass for add operations.
module alu_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ*3-1:0]        req_sel,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH:0]           rsp_y,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_sel,
    input  logic [WIDTH:0]           alu_y,
    output logic                     busy
);
    import alu_share_pkg::*;

    localparam int IDW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]      sel_q, sel_d;
    logic [WIDTH:0]  y_q, y_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gIdx;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) uPick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gIdx)
    );

    // Grant and operand capture happen only in IDLE; ready is masked while reset is held.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        y_d       = y_q;
        req_ready = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = '0;
        case (state_q)
            ST_IDLE: begin
                if (rst_n && (|req_valid)) begin
                    req_ready = gnt;
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            a_d   = req_a[i*WIDTH +: WIDTH];
                            b_d   = req_b[i*WIDTH +: WIDTH];
                            sel_d = req_sel[i*3 +: 3];
                        end
                    end
                    id_d = gIdx;
                    if (gIdx == IDW'(NREQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gIdx + 1'b1;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                alu_sel = sel_q;
                y_d     = alu_y;
`ifdef ALU_SHARE_COMP_EN
                state_d = (sel_q == SEL_ADD) ? ST_COMP : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef ALU_SHARE_COMP_EN
            ST_COMP: begin
                alu_a   = y_q[WIDTH-1:0];
                alu_b   = WIDTH'(alu_comp(COMP_W'(a_q), COMP_W'(b_q)));
                alu_sel = SEL_ADD;
                y_d     = {y_q[WIDTH] | alu_y[WIDTH], alu_y[WIDTH-1:0]};
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            y_q      <= y_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_y     = y_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a stand-in ALU and an arithmetic reference model.
// Follows ALU_SHARE_COMP_EN to pick expected latency and compensated results.
`timescale 1ns/1ps
module tb_alu_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
`ifdef ALU_SHARE_COMP_EN
    localparam bit COMP_ON = 1'b1;
    localparam int LAT     = 3;
`else
    localparam bit COMP_ON = 1'b0;
    localparam int LAT     = 2;
`endif

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic [NREQ*3-1:0]       req_sel;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_id;
    logic [WIDTH:0]          rsp_y;
    logic [WIDTH-1:0]        alu_a;
    logic [WIDTH-1:0]        alu_b;
    logic [2:0]              alu_sel;
    logic [WIDTH:0]          alu_y;
    logic                    busy;

    logic [WIDTH-1:0] opA [NREQ];
    logic [WIDTH-1:0] opB [NREQ];
    logic [2:0]       opS [NREQ];

    int vecCount;
    int missCount;
    int modelPtr;

    typedef struct {
        int rid;
        int a;
        int b;
        int sel;
        int yOff;
        int yOn;
    } vec_t;

    vec_t tbl [10];

    alu_share_arb #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .busy      (busy)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : gPack
        assign req_a[gi*WIDTH +: WIDTH] = opA[gi];
        assign req_b[gi*WIDTH +: WIDTH] = opB[gi];
        assign req_sel[gi*3 +: 3]       = opS[gi];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU; its add is exact so compensation shows up as a visible offset.
    function automatic logic [WIDTH:0] aluFn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] s);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a, 1'b0};
            3'd6:    return {2'b00, a[WIDTH-1:1]};
            default: return {1'b0, b};
        endcase
    endfunction

    assign alu_y = aluFn(alu_a, alu_b, alu_sel);

    function automatic int refY(input int a, input int b, input int sel);
        int y;
        int c;
        int s;
        case (sel)
            0:       y = a + b;
            1:       y = (a - b + 131072) % 131072;
            2:       y = a & b;
            3:       y = a | b;
            4:       y = a ^ b;
            5:       y = a * 2;
            6:       y = a / 2;
            default: y = b;
        endcase
        if (COMP_ON && sel == 0) begin
            c = ((a / 2) % 2) * ((b / 2) % 2) * 4 + (a % 2) * (b % 2) * 2;
            s = (y % 65536) + c;
            y = ((y / 65536) | (s / 65536)) * 65536 + (s % 65536);
        end
        return y;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitRsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Runs one lone-requester operation; starts and ends on a falling edge with the DUT idle.
    task automatic applyStimulus(input int id, input int a, input int b, input int sel,
                                 output logic [31:0] gotY, output logic [31:0] gotId, output int lat);
        int waited;
        opA[id]   = WIDTH'(a);
        opB[id]   = WIDTH'(b);
        opS[id]   = 3'(sel);
        req_valid = NREQ'(1 << id);
        #1;
        waited = 0;
        while (req_ready !== req_valid && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("lone grant", 32'(req_ready), 32'(1 << id));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        modelPtr  = (id + 1) % NREQ;
        waitRsp(lat);
        gotY      = 32'(rsp_y);
        gotId     = 32'(rsp_id);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] gotY;
        logic [31:0] gotId;
        logic [3:0]  pending;
        int lat;
        int g;
        int nGrant;
        int nRsp;
        int cyc;

        vecCount  = 0;
        missCount = 0;
        modelPtr  = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = '0;
            opB[i] = '0;
            opS[i] = '0;
        end

        tbl[0] = '{0, 'hFFFF, 'h0001, 0, 'h10000, 'h10002};
        tbl[1] = '{1, 'h0003, 'h0003, 0, 'h00006, 'h0000C};
        tbl[2] = '{2, 'h0005, 'h0007, 1, 'h1FFFE, 'h1FFFE};
        tbl[3] = '{3, 'hF0F0, 'h3C3C, 2, 'h03030, 'h03030};
        tbl[4] = '{0, 'hF000, 'h000F, 3, 'h0F00F, 'h0F00F};
        tbl[5] = '{1, 'hFFFF, 'h00FF, 4, 'h0FF00, 'h0FF00};
        tbl[6] = '{2, 'h8001, 'h0000, 5, 'h10002, 'h10002};
        tbl[7] = '{3, 'h8001, 'h0000, 6, 'h04000, 'h04000};
        tbl[8] = '{0, 'h0000, 'h1234, 7, 'h01234, 'h01234};
        tbl[9] = '{1, 'hFFFF, 'hFFFF, 0, 'h1FFFE, 'h10004};

        // Reset held with every requester asking.
        req_valid = '1;
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset rsp_id", 32'(rsp_id), 0);
        checkOutput("reset rsp_y", 32'(rsp_y), 0);
        checkOutput("reset alu_a", 32'(alu_a), 0);
        checkOutput("reset alu_b", 32'(alu_b), 0);
        checkOutput("reset alu_sel", 32'(alu_sel), 0);
        checkOutput("reset busy", 32'(busy), 0);
        req_valid = '0;
        rst_n     = 1'b1;
        @(negedge clk);

        applyStimulus(2, 'h4, 'h8, 0, gotY, gotId, lat);
        checkOutput("single latency", 32'(lat), 32'(LAT));
        checkOutput("single rsp_id", gotId, 2);
        checkOutput("single rsp_y", gotY, 'hC);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].rid, tbl[i].a, tbl[i].b, tbl[i].sel, gotY, gotId, lat);
            checkOutput("table rsp_y", gotY, COMP_ON ? 32'(tbl[i].yOn) : 32'(tbl[i].yOff));
            checkOutput("table rsp_id", gotId, 32'(tbl[i].rid));
            checkOutput("table latency", 32'(lat),
                        (COMP_ON && tbl[i].sel == 0) ? 32'(3) : 32'(2));
        end

        // Compensation pass visible on the shared ALU bus.
        opA[3] = 16'h0003;
        opB[3] = 16'h0003;
        opS[3] = 3'd0;
        req_valid = 4'b1000;
        #1;
        checkOutput("comp grant", 32'(req_ready), 32'h8);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        modelPtr  = 0;
        checkOutput("exec alu_a", 32'(alu_a), 3);
        checkOutput("exec alu_b", 32'(alu_b), 3);
        checkOutput("exec alu_sel", 32'(alu_sel), 0);
`ifdef ALU_SHARE_COMP_EN
        @(negedge clk);
        checkOutput("comp alu_a", 32'(alu_a), 6);
        checkOutput("comp alu_b", 32'(alu_b), 6);
        checkOutput("comp alu_sel", 32'(alu_sel), 0);
`endif
        @(negedge clk);
        checkOutput("comp rsp_valid", 32'(rsp_valid), 1);
        checkOutput("comp rsp_y", 32'(rsp_y), 32'(refY(3, 3, 0)));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Back-pressure: response held while another requester waits.
        opA[0] = 16'h1111;
        opB[0] = 16'h2222;
        opS[0] = 3'd4;
        opA[1] = 16'h0100;
        opB[1] = 16'h0023;
        opS[1] = 3'd1;
        req_valid = 4'b0001;
        #1;
        checkOutput("bp grant0", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0010;
        modelPtr  = 1;
        waitRsp(lat);
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp rsp_valid", 32'(rsp_valid), 1);
            checkOutput("bp rsp_y", 32'(rsp_y), 32'(refY('h1111, 'h2222, 4)));
            checkOutput("bp rsp_id", 32'(rsp_id), 0);
            checkOutput("bp req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checkOutput("bp idle busy", 32'(busy), 0);
        checkOutput("bp next grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        modelPtr  = 2;
        waitRsp(lat);
        checkOutput("bp second y", 32'(rsp_y), 32'(refY('h100, 'h23, 1)));
        checkOutput("bp second id", 32'(rsp_id), 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Randomized contention against the round-robin reference.
        for (int r = 0; r < 15; r++) begin
            pending = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                opA[i] = WIDTH'($urandom_range(0, 65535));
                opB[i] = WIDTH'($urandom_range(0, 65535));
                opS[i] = 3'($urandom_range(0, 7));
            end
            req_valid = pending;
            while (pending != 0) begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && pending[(modelPtr + k) % NREQ]) begin
                        g = (modelPtr + k) % NREQ;
                    end
                end
                #1;
                checkOutput("rand grant", 32'(req_ready), 32'(1 << g));
                @(posedge clk);
                @(negedge clk);
                pending[g] = 1'b0;
                req_valid  = pending;
                modelPtr   = (g + 1) % NREQ;
                waitRsp(lat);
                checkOutput("rand rsp_id", 32'(rsp_id), 32'(g));
                checkOutput("rand rsp_y", 32'(rsp_y),
                            32'(refY(int'(opA[g]), int'(opB[g]), int'(opS[g]))));
                rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = 1'b0;
            end
        end

        // Fairness from a fresh reset with everyone asking continuously.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        modelPtr = 0;
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = WIDTH'(i + 1);
            opB[i] = 16'h0010;
            opS[i] = 3'd0;
        end
        rsp_ready = 1'b1;
        req_valid = '1;
        nGrant    = 0;
        nRsp      = 0;
        cyc       = 0;
        while (nGrant < 8 && cyc < 80) begin
            #1;
            if (req_ready != '0) begin
                checkOutput("fair grant", 32'(req_ready), 32'(1 << (nGrant % NREQ)));
                nGrant++;
            end
            if (rsp_valid) begin
                checkOutput("fair rsp_id", 32'(rsp_id), 32'(nRsp % NREQ));
                checkOutput("fair rsp_y", 32'(rsp_y), 32'(refY(nRsp % NREQ + 1, 'h10, 0)));
                nRsp++;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("fair grant count", 32'(nGrant), 8);
        req_valid = '0;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("fair drained", 32'(busy), 0);
        rsp_ready = 1'b0;
        modelPtr  = 0;

        // Reset during EXEC discards the operation and rewinds the pointer.
        opA[2] = 16'h00AA;
        opB[2] = 16'h0055;
        opS[2] = 3'd3;
        req_valid = 4'b0100;
        #1;
        checkOutput("midrst grant", 32'(req_ready), 32'h4);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b1010;
        checkOutput("midrst exec alu_a", 32'(alu_a), 'hAA);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst busy", 32'(busy), 0);
        checkOutput("midrst rsp_valid", 32'(rsp_valid), 0);
        checkOutput("midrst rsp_y", 32'(rsp_y), 0);
        checkOutput("midrst rsp_id", 32'(rsp_id), 0);
        checkOutput("midrst alu_a", 32'(alu_a), 0);
        checkOutput("midrst alu_b", 32'(alu_b), 0);
        checkOutput("midrst alu_sel", 32'(alu_sel), 0);
        checkOutput("midrst req_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postrst grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        waitRsp(lat);
        checkOutput("postrst rsp_id", 32'(rsp_id), 1);
        checkOutput("postrst rsp_y", 32'(rsp_y),
                    32'(refY(int'(opA[1]), int'(opB[1]), int'(opS[1]))));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
